// File: rtl/apb_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_bridge_pkg                                                           |
// | Shared widths, command/response word layouts and sequencer states.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package apb_bridge_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int CMD_W      = 1 + APB_ADDR_W + APB_DATA_W;
  localparam int RSP_W      = 2 + APB_DATA_W;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic                  write;
    logic                  slverr;
    logic [APB_DATA_W-1:0] rdata;
  } apb_rsp_t;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_FETCH  = 3'd1,
    SEQ_SETUP  = 3'd2,
    SEQ_ACCESS = 3'd3,
    SEQ_RESP   = 3'd4
  } apb_seq_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_master_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_master_seq                                                           |
// | APB3 master: pops a command FIFO word, runs SETUP/ACCESS, pushes one     |
// | response word. Optional ACCESS timeout under APB_SEQ_TIMEOUT_EN.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module apb_master_seq
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                   pclk,
  input  logic                   prst_n,
  input  logic                   cmd_rempty,
  output logic                   cmd_rinc,
  input  logic [ADDR_W+DATA_W:0] cmd_rdata,
  input  logic                   rsp_wfull,
  output logic                   rsp_winc,
  output logic [DATA_W+1:0]      rsp_wdata,
  output logic                   psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [DATA_W-1:0]      prdata,
  input  logic                   pready,
  input  logic                   pslverr,
`ifdef APB_SEQ_TIMEOUT_EN
  output logic                   timeout_evt,
`endif
  output logic                   busy
);

  localparam logic [2:0] c_ST_IDLE   = SEQ_IDLE;
  localparam logic [2:0] c_ST_FETCH  = SEQ_FETCH;
  localparam logic [2:0] c_ST_SETUP  = SEQ_SETUP;
  localparam logic [2:0] c_ST_ACCESS = SEQ_ACCESS;
  localparam logic [2:0] c_ST_RESP   = SEQ_RESP;

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              w_to_hit;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_write;
  logic              r_rsp_slverr;
  logic [DATA_W-1:0] r_rsp_rdata;

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int               c_CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_to_cnt;
  logic               r_to_evt;

  // A pready in the terminal cycle takes priority over the timeout.
  assign w_to_hit = (r_state == c_ST_ACCESS) && !pready && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_to_cnt <= '0;
      r_to_evt <= 1'b0;
    end else begin
      r_to_evt <= w_to_hit;
      if (r_state == c_ST_SETUP) begin
        r_to_cnt <= '0;
      end else if ((r_state == c_ST_ACCESS) && !pready) begin
        r_to_cnt <= r_to_cnt + c_CNT_W'(1);
      end
    end
  end

  assign timeout_evt = r_to_evt;
`else
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:   if (!cmd_rempty) w_state_nxt = c_ST_FETCH;
      c_ST_FETCH:  w_state_nxt = c_ST_SETUP;
      c_ST_SETUP:  w_state_nxt = c_ST_ACCESS;
      c_ST_ACCESS: if (pready || w_to_hit) w_state_nxt = c_ST_RESP;
      c_ST_RESP:   if (!rsp_wfull) w_state_nxt = c_ST_IDLE;
      default:     w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO read data is valid only in FETCH; the APB fields hold from then on.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
    end else if (r_state == c_ST_FETCH) begin
      r_pwrite <= cmd_rdata[ADDR_W+DATA_W];
      r_paddr  <= cmd_rdata[DATA_W +: ADDR_W];
      r_pwdata <= cmd_rdata[DATA_W-1:0];
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      r_rsp_write  <= 1'b0;
      r_rsp_slverr <= 1'b0;
      r_rsp_rdata  <= '0;
    end else if (r_state == c_ST_ACCESS) begin
      if (pready) begin
        r_rsp_write  <= r_pwrite;
        r_rsp_slverr <= pslverr;
        r_rsp_rdata  <= r_pwrite ? '0 : prdata;
      end else if (w_to_hit) begin
        r_rsp_write  <= r_pwrite;
        r_rsp_slverr <= 1'b1;
        r_rsp_rdata  <= '0;
      end
    end
  end

  // Strobes decode from state so reset removes them without waiting for a clock.
  assign cmd_rinc  = (r_state == c_ST_IDLE) && !cmd_rempty;
  assign rsp_winc  = (r_state == c_ST_RESP) && !rsp_wfull;
  assign psel      = (r_state == c_ST_SETUP) || (r_state == c_ST_ACCESS);
  assign penable   = (r_state == c_ST_ACCESS);
  assign busy      = (r_state != c_ST_IDLE);
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_wdata = {r_rsp_write, r_rsp_slverr, r_rsp_rdata};

endmodule

`default_nettype wire
